shift_sequencer: RTL
====================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DATA_W, 16, datapath width; fixed at 16 to match the single-step shifter.
- AMT_W, 4, shift-amount width (0..15).
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, input, 1, single clock; all state updates on its rising edge.
- reset, input, 1, asynchronous, active-high.
- in_valid, input, 1, request present.
- in_ready, output, 1, block can accept a request.
- din, input, DATA_W, operand.
- op, input, 2, 00 pass, 01 LSL, 10 LSR, 11 ASR.
- amt, input, AMT_W, number of 1-bit steps.
- out_valid, output, 1, result present.
- out_ready, input, 1, consumer takes the result.
- dout, output, DATA_W, result.
- cout, output, 1, last bit shifted out.
- busy, output, 1, high when the state is not IDLE.
REQ-003 The block SHALL use one clock, clk, and SHALL use an asynchronous, active-high reset named reset.

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-005 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-006 Accept: in IDLE with in_valid=1, the block SHALL latch din into acc, amt into cnt and op into op_q, and SHALL clear cout_q.
REQ-007 After accept, the next state SHALL be DONE if amt==0 or op==00, and SHALL be SHIFT otherwise.
REQ-008 Each clk edge in SHIFT SHALL apply one 1-bit step to acc and decrement cnt. The step SHALL be:
- LSL: shift left, fill 0.
- LSR: shift right, fill 0.
- ASR: shift right, replicate bit 15.
REQ-009 SHIFT SHALL go to DONE on the edge where cnt==1; the total SHIFT occupancy SHALL be exactly amt cycles.
REQ-010 Latency SHALL be amt+1 edges from accept to out_valid=1, and 1 edge for amt==0 or op==00.
REQ-011 In DONE, dout and cout SHALL hold stable until out_valid and out_ready are both 1; on that edge the state SHALL return to IDLE.
REQ-012 A new request SHALL be accepted no earlier than the edge after the handshake; there SHALL be no same-cycle overlap of a result handshake and an accept.
REQ-013 in_valid, din, op and amt SHALL be ignored while not in IDLE.
REQ-014 Arithmetic SHALL be modulo 16 bits; no step SHALL widen acc.
REQ-015 op==00 with a nonzero amt SHALL return din unchanged with cout=0.

Reset
REQ-016 While reset=1, regardless of clk: state=IDLE, acc=0, cnt=0, op_q=00, cout_q=0.
REQ-017 Outputs during reset SHALL be: in_ready=1, out_valid=0, busy=0, dout=0x0000, cout=0.
REQ-018 A reset asserted during SHIFT or DONE SHALL discard the operation with no result produced; the first accept SHALL be possible on the first edge after reset deasserts.

Configuration
REQ-019 Macro SHIFT_SEQ_CARRY_EN defined: cout SHALL equal the bit shifted out by the final step. That bit is:
- bit 15 of the pre-step acc for LSL.
- bit 0 of the pre-step acc for LSR and ASR.
REQ-020 Macro SHIFT_SEQ_CARRY_EN undefined: the cout port SHALL remain present, SHALL be tied to 0, and no carry register SHALL be inferred.

Structure
REQ-021 The package shift_seq_pkg SHALL hold:
- the op encodings (OP_PASS, OP_LSL, OP_LSR, OP_ASR);
- the state enum (IDLE, SHIFT, DONE);
- DATA_W and AMT_W defaults.
REQ-022 The one-step datapath SHALL be one instance of the existing combinational sub-module shifter (in[15:0], shift[1:0], sout[15:0]), driven by acc and op_q. The sequencer SHALL contain only control logic, acc, cnt, op_q and cout_q.

Verification
REQ-023 The bench SHALL cover these scenarios:
- ASR: din=0x8001, op=11, amt=3 -> dout=0xF000, out_valid on the 4th edge after accept, cout=0 (CARRY_EN).
- LSL: din=0xF00F, op=01, amt=4 -> dout=0x00F0, cout=1 (CARRY_EN) or 0 (no macro), latency 5 edges.
- LSR maximum: din=0x8000, op=10, amt=15 -> dout=0x0001, busy high 16 cycles, in_ready=0 throughout.
- Zero and pass: amt=0 with din=0x1234 -> dout=0x1234 after 1 edge; op=00 with amt=7 -> dout=0x1234 after 1 edge, cout=0.
- Backpressure: out_ready=0 for 5 cycles in DONE with in_valid=1 -> dout stable, no new accept; in_ready=1 on the edge after the handshake.
- Reset mid-op: reset pulsed during the 3rd SHIFT cycle of amt=10 -> out_valid never rises for that request; the next request din=0x0003, op=01, amt=1 -> 0x0006.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared definitions for the shift sequencer: op encodings, FSM states, default widths.
// Carry tracking is enabled in the top level by defining SHIFT_SEQ_CARRY_EN.
package shift_seq_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned AMT_W_DEF  = 4;

  typedef enum logic [1:0] {
    OP_PASS = 2'b00,
    OP_LSL  = 2'b01,
    OP_LSR  = 2'b10,
    OP_ASR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_sequencer_shifter.sv
// Combinational single-step 16-bit shifter: pass, LSL, LSR or ASR by one bit.
module shifter (
  input  logic [15:0] in,
  input  logic [1:0]  shift,
  output logic [15:0] sout
);

  always_comb begin
    sout = in;
    unique case (shift)
      2'b00: sout = in;
      2'b01: sout = {in[14:0], 1'b0};
      2'b10: sout = {1'b0, in[15:1]};
      2'b11: sout = {in[15], in[15:1]};
      default: sout = in;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: one 1-bit step per clock through an external shifter instance.
// Define SHIFT_SEQ_CARRY_EN to report the last bit shifted out on cout.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned AMT_W  = AMT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] din,
  input  logic [1:0]        op,
  input  logic [AMT_W-1:0]  amt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] dout,
  output logic              cout,
  output logic              busy
);

  state_e             state_q;
  logic [DATA_W-1:0]  acc_q;
  logic [DATA_W-1:0]  acc_step;
  logic [AMT_W-1:0]   cnt_q;
  op_e                op_q;

  shifter u_shifter (
    .in    (acc_q),
    .shift (op_q),
    .sout  (acc_step)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      op_q    <= OP_PASS;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            acc_q   <= din;
            cnt_q   <= amt;
            op_q    <= op_e'(op);
            // Pass and zero-amount requests skip straight to the result.
            state_q <= (amt == '0 || op_e'(op) == OP_PASS) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q - AMT_W'(1);
          if (cnt_q == AMT_W'(1)) state_q <= DONE;
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SHIFT_SEQ_CARRY_EN
  logic cout_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cout_q <= 1'b0;
    end else if (state_q == IDLE && in_valid) begin
      cout_q <= 1'b0;
    end else if (state_q == SHIFT) begin
      cout_q <= (op_q == OP_LSL) ? acc_q[DATA_W-1] : acc_q[0];
    end
  end

  assign cout = cout_q;
`else
  assign cout = 1'b0;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign dout      = acc_q;

endmodule
